// File: rtl/trig_event_recorder.sv
// rtl/trig_event_recorder.sv - captures one timestamped record per trigger firing into a FIFO, read out as 5 x 32-bit words
// Optional: define TREC_HIT_ACCUM_EN to store the OR of the hit pattern over the fire cycle and the 3 cycles before it.
module trig_event_recorder #(
  parameter int DEPTH = 16,
  parameter int NCH   = 64,
  parameter int TS_W  = 56
) (
  input  logic                     clk_adc,
  input  logic                     nrst,
  input  logic [15:0]              trig_out,
  input  logic [7:0]               trig_id,
  input  logic [TS_W-1:0]          timestamp,
  input  logic [NCH-1:0]           hit_pattern,
  input  logic                     clear,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [31:0]              rd_data,
  output logic                     rd_last,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     full,
  output logic [15:0]              drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = 8 + 16 + TS_W + NCH;

  logic              trig_any;
  logic              trig_any_q;
  logic              fire;
  logic              wr_en;
  logic              drop_en;
  logic              xfer;
  logic              pop;
  logic [15:0]       seq;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [2:0]        w;
  logic [NCH-1:0]    hit_store;
  logic [RW-1:0]     mem [DEPTH];
  logic [RW-1:0]     rec;
  logic [7:0]        r_id;
  logic [15:0]       r_seq;
  logic [TS_W-1:0]   r_ts;
  logic [NCH-1:0]    r_hit;

  assign trig_any = |trig_out;
  assign fire     = trig_any & ~trig_any_q;

  // full is the registered state, so a pop in the same cycle cannot make room for a fire
  assign wr_en    = fire & ~full & ~clear;
  assign drop_en  = fire & full & ~clear;
  assign xfer     = rd_valid & rd_ready & ~clear;
  assign pop      = xfer & (w == 3'd4);

  assign rd_valid = (occupancy != '0);
  assign full     = (occupancy == (AW + 1)'(DEPTH));

  // Edge-detect register; keeps tracking through clear so a held pulse is not re-counted
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      trig_any_q <= 1'b0;
    end else begin
      trig_any_q <= trig_any;
    end
  end

`ifdef TREC_HIT_ACCUM_EN
  logic [NCH-1:0] hist_1;
  logic [NCH-1:0] hist_2;
  logic [NCH-1:0] hist_3;

  // Three-cycle hit history so slightly early hits still appear in the record
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      hist_1 <= '0;
      hist_2 <= '0;
      hist_3 <= '0;
    end else if (clear) begin
      hist_1 <= '0;
      hist_2 <= '0;
      hist_3 <= '0;
    end else begin
      hist_1 <= hit_pattern;
      hist_2 <= hist_1;
      hist_3 <= hist_2;
    end
  end

  assign hit_store = hit_pattern | hist_1 | hist_2 | hist_3;
`else
  assign hit_store = hit_pattern;
`endif

  // Record storage; contents need no reset because occupancy gates visibility
  always_ff @(posedge clk_adc) begin
    if (wr_en) begin
      mem[wr_ptr] <= {trig_id, seq, timestamp, hit_store};
    end
  end

  // Pointers, occupancy, sequence number, drop counter and word index
  always_ff @(posedge clk_adc or negedge nrst) begin
    if (!nrst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      w          <= 3'd0;
      seq        <= 16'd0;
      drop_count <= 16'd0;
    end else if (clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      w          <= 3'd0;
      seq        <= 16'd0;
      drop_count <= 16'd0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      // Dropped events still consume a sequence number so gaps are visible downstream
      if (fire) begin
        seq <= seq + 16'd1;
      end
      if (drop_en && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
      if (xfer) begin
        if (w == 3'd4) begin
          w      <= 3'd0;
          rd_ptr <= rd_ptr + AW'(1);
        end else begin
          w      <= w + 3'd1;
        end
      end
      case ({wr_en, pop})
        2'b10:   occupancy <= occupancy + (AW + 1)'(1);
        2'b01:   occupancy <= occupancy - (AW + 1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign rec = mem[rd_ptr];
  assign {r_id, r_seq, r_ts, r_hit} = rec;

  // Show-ahead word mux over the head record; driven to zero when nothing is stored
  always_comb begin
    rd_data = 32'd0;
    rd_last = 1'b0;
    if (rd_valid) begin
      case (w)
        3'd0:    rd_data = {8'hE7, r_id, r_seq};
        3'd1:    rd_data = {8'h00, r_ts[55:32]};
        3'd2:    rd_data = r_ts[31:0];
        3'd3:    rd_data = r_hit[63:32];
        3'd4: begin
          rd_data = r_hit[31:0];
          rd_last = 1'b1;
        end
        default: rd_data = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_trig_event_recorder.sv
// tb/tb_trig_event_recorder.sv - scoreboard bench for trig_event_recorder
module tb_trig_event_recorder;

  localparam int DEPTH = 16;

  logic                     clk_adc = 1'b0;
  logic                     nrst = 1'b0;
  logic [15:0]              trig_out = '0;
  logic [7:0]               trig_id = '0;
  logic [55:0]              timestamp = '0;
  logic [63:0]              hit_pattern = '0;
  logic                     clear = 1'b0;
  logic                     rd_ready = 1'b0;
  logic                     rd_valid;
  logic [31:0]              rd_data;
  logic                     rd_last;
  logic [$clog2(DEPTH):0]   occupancy;
  logic                     full;
  logic [15:0]              drop_count;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] exp_q[$];
  logic [15:0] mseq = '0;
  logic        stall_prev = 1'b0;
  logic [31:0] held = '0;
  logic [32:0] e;

  always #5 clk_adc = ~clk_adc;

  trig_event_recorder #(.DEPTH(DEPTH)) dut (
    .clk_adc     (clk_adc),
    .nrst        (nrst),
    .trig_out    (trig_out),
    .trig_id     (trig_id),
    .timestamp   (timestamp),
    .hit_pattern (hit_pattern),
    .clear       (clear),
    .rd_ready    (rd_ready),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_last     (rd_last),
    .occupancy   (occupancy),
    .full        (full),
    .drop_count  (drop_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk_adc);
    #1;
  endtask

  task automatic push_event(input logic [7:0] id, input logic [15:0] sq,
                            input logic [55:0] ts, input logic [63:0] hit);
    exp_q.push_back({1'b0, 8'hE7, id, sq});
    exp_q.push_back({1'b0, 8'h00, ts[55:32]});
    exp_q.push_back({1'b0, ts[31:0]});
    exp_q.push_back({1'b0, hit[63:32]});
    exp_q.push_back({1'b1, hit[31:0]});
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    trig_out = '0;
    clear = 1'b0;
    rd_ready = 1'b0;
    hit_pattern = '0;
    repeat (2) tick();
    exp_q.delete();
    mseq = '0;
    nrst = 1'b1;
    tick();
  endtask

  // One rising edge held for hi cycles then one low cycle; stored says whether it should fit
  task automatic pulse(input logic [7:0] id, input logic [55:0] ts, input logic [63:0] hit,
                       input int hi, input bit stored);
    trig_out = 16'h0100;
    trig_id = id;
    timestamp = ts;
    hit_pattern = hit;
    if (stored) push_event(id, mseq, ts, hit);
    mseq++;
    repeat (hi) tick();
    trig_out = '0;
    tick();
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || rd_valid) && n < 300) begin
      tick();
      n++;
    end
    check(tag, n < 300, 1);
  endtask

  // Output monitor: compares every accepted word against the scoreboard and checks stall stability
  always @(negedge clk_adc) begin
    if (!nrst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && rd_valid) check("hold_data", rd_data, held);
      if (rd_valid && rd_ready) begin
        check("word_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("rd_data", rd_data, e[31:0]);
          check("rd_last", rd_last, e[32]);
        end
      end
      stall_prev = rd_valid && !rd_ready && !clear;
      held = rd_data;
    end
  end

  initial begin
    #1;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_last", rd_last, 0);
    check("rst_full", full, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_drop_count", drop_count, 0);

    // Basic capture: one event from a 16-cycle pulse
    do_reset();
    rd_ready = 1'b1;
    trig_out = 16'h0100;
    trig_id = 8'd3;
    timestamp = 56'h12_3456_789A_BCDE;
    hit_pattern = 64'h8000_0000_0000_0011;
    push_event(8'd3, mseq, timestamp, hit_pattern);
    mseq++;
    tick();
    check("latency_rd_valid", rd_valid, 1);
    check("latency_occupancy", occupancy, 1);
    check("first_word", rd_data, 32'hE703_0000);
    repeat (15) tick();
    trig_out = '0;
    wait_drain("basic_drain");
    check("basic_occupancy", occupancy, 0);

    // Edge-only counting: long pulse, one low cycle, short pulse
    do_reset();
    rd_ready = 1'b1;
    pulse(8'd7, 56'h00_0000_0000_1111, 64'h1, 40, 1'b1);
    pulse(8'd8, 56'h00_0000_0000_2222, 64'h2, 1, 1'b1);
    wait_drain("edge_drain");
    check("edge_drop_count", drop_count, 0);

    // Overflow: 20 pulses into a 16-deep FIFO with no readout
    do_reset();
    for (int i = 0; i < 20; i++) begin
      pulse(8'(i), 56'(i * 1000), 64'(i) << 32 | 64'(i), 1, i < DEPTH);
    end
    check("ovf_full", full, 1);
    check("ovf_occupancy", occupancy, DEPTH);
    check("ovf_drop_count", drop_count, 4);
    rd_ready = 1'b1;
    wait_drain("ovf_drain");
    check("ovf_drained_full", full, 0);
    check("ovf_drop_kept", drop_count, 4);

    // Clear coincident with a fire edge
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) pulse(8'(40 + i), 56'(i + 77), 64'(i), 1, 1'b1);
    check("clr_pre_occupancy", occupancy, 3);
    trig_out = 16'h0100;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_q.delete();
    mseq = '0;
    check("clr_occupancy", occupancy, 0);
    check("clr_rd_valid", rd_valid, 0);
    check("clr_drop_count", drop_count, 0);
    trig_out = '0;
    tick();
    rd_ready = 1'b1;
    pulse(8'd9, 56'hAB_CDEF_0123_4567, 64'hDEAD_BEEF_0000_0001, 2, 1'b1);
    wait_drain("clr_drain");

    // Backpressure: rd_ready toggles every cycle during the packet
    do_reset();
    pulse(8'h55, 56'h01_0203_0405_0607, 64'h1122_3344_5566_7788, 1, 1'b1);
    for (int n = 0; n < 60 && exp_q.size() != 0; n++) begin
      rd_ready = ~rd_ready;
      tick();
    end
    rd_ready = 1'b1;
    wait_drain("bp_drain");

    // Hit accumulation window: bit 5 three cycles early, bit 9 on the fire cycle
    do_reset();
    rd_ready = 1'b1;
    hit_pattern = 64'h20;
    tick();
    hit_pattern = '0;
    repeat (2) tick();
    hit_pattern = 64'h200;
    trig_out = 16'h0100;
    trig_id = 8'd1;
    timestamp = 56'h5;
`ifdef TREC_HIT_ACCUM_EN
    push_event(8'd1, mseq, 56'h5, 64'h220);
`else
    push_event(8'd1, mseq, 56'h5, 64'h200);
`endif
    mseq++;
    tick();
    hit_pattern = '0;
    trig_out = '0;
    wait_drain("hit_drain");
    check("final_occupancy", occupancy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
